// File: rtl/led_array_pkg.sv
// Shared defaults, cell-bus type and column one-hot helper for the LED matrix driver.
package led_array_pkg;

    localparam int unsigned LED_ROWS = 4;
    localparam int unsigned LED_COLS = 4;
    localparam int unsigned LED_N    = 4;

    // Widest column count the helper can encode; callers size-cast down to COLS.
    localparam int unsigned MAX_COLS = 64;

    typedef logic [LED_ROWS*LED_COLS-1:0] cells_t;

    function automatic logic [MAX_COLS-1:0] col_onehot(input int unsigned x,
                                                       input int unsigned cols);
        logic [MAX_COLS-1:0] one;
        one = '0;
        one[0] = 1'b1;
        col_onehot = '0;
        if (x < cols) begin
            col_onehot = one << x;
        end
    endfunction

endpackage

// File: rtl/led_col_decoder.sv
// Combinational column decoder: x -> one-hot column drive plus the per-column cell mask table.
module led_col_decoder
    import led_array_pkg::*;
#(
    parameter int unsigned ROWS = LED_ROWS,
    parameter int unsigned COLS = LED_COLS,
    parameter int unsigned N    = LED_N,
    localparam int unsigned XW  = $clog2(N) + 1
) (
    input  logic [XW-1:0]             x,
    output logic [COLS-1:0]           col_oh,
    output logic [COLS*ROWS*COLS-1:0] column_masks
);

    assign col_oh = COLS'(col_onehot(32'(x), COLS));

    // Mask k marks cell bits {COLS*r + k} for every row r.
    always_comb begin
        column_masks = '0;
        for (int unsigned k = 0; k < COLS; k++) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                column_masks[k*ROWS*COLS + COLS*r + k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_array_driver.sv
// Registered LED matrix column scanner. Optional macro LED_DRIVER_ROWS_ACTIVE_LOW_EN
// inverts the row drive for common-anode sink drivers.
module led_array_driver
    import led_array_pkg::*;
#(
    parameter int unsigned ROWS = LED_ROWS,
    parameter int unsigned COLS = LED_COLS,
    parameter int unsigned N    = LED_N,
    localparam int unsigned XW  = $clog2(N) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [ROWS*COLS-1:0] cells,
    input  logic [XW-1:0]        x,
    output logic [ROWS-1:0]      rows,
    output logic [COLS-1:0]      cols
);

    logic [COLS-1:0]           col_oh;
    logic [COLS*ROWS*COLS-1:0] column_masks;
    logic [ROWS*COLS-1:0]      sel_mask;
    logic [ROWS*COLS-1:0]      hit;
    logic [ROWS-1:0]           rows_on;
    logic [ROWS-1:0]           rows_d, rows_q;
    logic [COLS-1:0]           cols_d, cols_q;

    led_col_decoder #(
        .ROWS (ROWS),
        .COLS (COLS),
        .N    (N)
    ) u_col_decoder (
        .x            (x),
        .col_oh       (col_oh),
        .column_masks (column_masks)
    );

    // Out-of-range x yields an all-zero col_oh, so no mask is selected.
    always_comb begin
        sel_mask = '0;
        for (int unsigned k = 0; k < COLS; k++) begin
            if (col_oh[k]) begin
                sel_mask = sel_mask | column_masks[k*ROWS*COLS +: ROWS*COLS];
            end
        end
        hit = cells & sel_mask;
    end

    always_comb begin
        rows_on = '0;
        cols_d  = '0;
        if (ena) begin
            cols_d = col_oh;
            for (int unsigned r = 0; r < ROWS; r++) begin
                rows_on[r] = |hit[COLS*r +: COLS];
            end
        end
`ifdef LED_DRIVER_ROWS_ACTIVE_LOW_EN
        rows_d = ~rows_on;
`else
        rows_d = rows_on;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef LED_DRIVER_ROWS_ACTIVE_LOW_EN
            rows_q <= '1;
`else
            rows_q <= '0;
`endif
            cols_q <= '0;
        end else begin
            rows_q <= rows_d;
            cols_q <= cols_d;
        end
    end

    assign rows = rows_q;
    assign cols = cols_q;

endmodule

// File: tb/tb_led_array_driver.sv
// Self-checking bench for led_array_driver (ROWS=COLS=N=4) against a matrix reference model.
module tb_led_array_driver;

    localparam int unsigned R = 4;
    localparam int unsigned C = 4;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [15:0] cells;
    logic [2:0]  x;
    logic [3:0]  rows;
    logic [3:0]  cols;

    int unsigned n_cmp;
    int unsigned n_err;

    led_array_driver #(
        .ROWS (4),
        .COLS (4),
        .N    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .cells (cells),
        .x     (x),
        .rows  (rows),
        .cols  (cols)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LED_DRIVER_ROWS_ACTIVE_LOW_EN
    localparam logic [3:0] ROW_INV = 4'hF;
`else
    localparam logic [3:0] ROW_INV = 4'h0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the matrix as a 2-D array of lit cells, then pick column x.
    task automatic model(input logic e, input logic [15:0] cv, input logic [2:0] xv,
                         output logic [3:0] er, output logic [3:0] ec);
        bit led [C][R];
        for (int c = 0; c < C; c++)
            for (int r = 0; r < R; r++)
                led[c][r] = cv[C*r + c];
        er = 4'h0;
        ec = 4'h0;
        if (e && int'(xv) < C) begin
            ec = 4'(1 << xv);
            for (int r = 0; r < R; r++) er[r] = led[xv][r];
        end
        er = er ^ ROW_INV;
    endtask

    // Decodes what a viewer of the physical matrix would see lit.
    task automatic decode(output bit lit [C][R], output int cnt);
        logic [3:0] on;
        on = rows ^ ROW_INV;
        cnt = 0;
        for (int c = 0; c < C; c++)
            for (int r = 0; r < R; r++) begin
                lit[c][r] = cols[c] && on[r];
                if (lit[c][r]) cnt++;
            end
    endtask

    task automatic print_status();
        bit lit [C][R];
        int cnt;
        decode(lit, cnt);
        for (int c = 0; c < C; c++)
            for (int r = 0; r < R; r++)
                if (lit[c][r]) $display("  LED (col %0d, row %0d) on", c, r);
    endtask

    task automatic step(input string tag, input logic e, input logic [15:0] cv, input logic [2:0] xv);
        logic [3:0] er, ec;
        ena   = e;
        cells = cv;
        x     = xv;
        model(e, cv, xv, er, ec);
        @(posedge clk);
        #1;
        check({tag, "_rows"}, 32'(rows), 32'(er));
        check({tag, "_cols"}, 32'(cols), 32'(ec));
    endtask

    initial begin
        bit lit [C][R];
        int cnt;
        n_cmp = 0;
        n_err = 0;

        // Get the outputs non-zero, then pull reset between edges.
        rst_n = 1'b1;
        ena   = 1'b1;
        cells = 16'hFFFF;
        x     = 3'd1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_rows", 32'(rows), 32'(ROW_INV));
        check("reset_cols", 32'(cols), 32'h0);
        @(posedge clk);
        #1;
        check("reset_hold_rows", 32'(rows), 32'(ROW_INV));
        check("reset_hold_cols", 32'(cols), 32'h0);
        #2;
        rst_n = 1'b1;

        step("blank", 1'b0, 16'hFFFF, 3'd0);

        for (int i = 0; i < 4; i++) step("full", 1'b1, 16'hFFFF, 3'(i));
        print_status();

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int xv = 0; xv < 4; xv++) begin
                    step("sweep", 1'b1, 16'(1 << (4*j + i)), 3'(xv));
                    decode(lit, cnt);
                    check("sweep_lit_cnt", 32'(cnt), (xv == i) ? 32'd1 : 32'd0);
                    if (xv == i) check("sweep_lit_pos", 32'(lit[i][j]), 32'd1);
                end

        step("x_eq_n", 1'b1, 16'hFFFF, 3'd4);
        step("x_max", 1'b1, 16'hFFFF, 3'd7);

`ifdef LED_DRIVER_ROWS_ACTIVE_LOW_EN
        step("al_lit", 1'b1, 16'h0001, 3'd0);
        check("al_rows_const", 32'(rows), 32'hE);
        step("al_blank", 1'b0, 16'h0001, 3'd0);
        check("al_blank_const", 32'(rows), 32'hF);
`endif

        for (int n = 0; n < 300; n++) begin
            step("rand", ($urandom_range(0, 7) != 0), 16'($urandom), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 24) == 0) begin
                #1;
                rst_n = 1'b0;
                #1;
                check("midscan_rst_rows", 32'(rows), 32'(ROW_INV));
                check("midscan_rst_cols", 32'(cols), 32'h0);
                #1;
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
